// File: rtl/bht_update_unit.sv
// bht_update_unit: buffers resolved branches in a FIFO and drains them as serialized
// read-modify-writes of 2-bit BHT counters; `BHT_UPD_STATS_EN adds update/flip counters.
module bht_update_unit #(
  parameter int IDX_W = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             res_valid,
  input  logic [IDX_W-1:0] res_idx,
  input  logic             res_taken,
  output logic             res_ready,
  input  logic             flush,
  output logic [IDX_W-1:0] bht_addr,
  output logic             bht_we,
  output logic [1:0]       bht_wdata,
  input  logic [1:0]       bht_rdata,
  output logic             upd_done,
  output logic             upd_pred,
  output logic             busy
`ifdef BHT_UPD_STATS_EN
  ,
  output logic [15:0]      stat_updates,
  output logic [15:0]      stat_flips
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  state_t state, state_nx;
  logic [IDX_W:0] fifo_mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [IDX_W-1:0] hold_idx;
  logic hold_taken, empty, full, push, pop;
  logic [1:0] cnt_nx;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign res_ready = !full;
  assign push = res_valid && !full && !flush;
  // RD never pops, so a pop is only ever taken from IDLE or WR
  assign pop = (state != RD) && !empty && !flush;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE;
      if (pop) rd_ptr <= rd_ptr + ONE;
    end
  end
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= {res_idx, res_taken};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {hold_idx, hold_taken} <= '0;
    else if (pop) {hold_idx, hold_taken} <= fifo_mem[rd_ptr[AW-1:0]];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = (state == RD) ? WR : pop ? RD : IDLE;
  end
  always_comb begin
    cnt_nx = hold_taken ? ((bht_rdata == 2'b11) ? 2'b11 : bht_rdata + 2'd1)
                        : ((bht_rdata == 2'b00) ? 2'b00 : bht_rdata - 2'd1);
    bht_addr = hold_idx;
    bht_we = state == WR;
    bht_wdata = bht_we ? cnt_nx : 2'b00;
    upd_done = bht_we;
    upd_pred = bht_wdata[1];
    busy = !empty || state != IDLE;
  end
`ifdef BHT_UPD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_updates <= '0;
      stat_flips <= '0;
    end else if (bht_we) begin
      stat_updates <= stat_updates + 16'd1;
      if (bht_wdata[1] != bht_rdata[1]) stat_flips <= stat_flips + 16'd1;
    end
  end
`endif
endmodule
